ff_emu_spi_ctrl: RTL and testbench
==================================

Name: ff_emu_spi_ctrl

Overview:
SPI slave sequencer for the fiber-emulator (FMU) control link. Oversamples the FMU SPI inputs in the system clock domain and decodes 16-bit frames from either chip select. Converts each frame into one register-bus transaction towards target 0 (CS0) or target 1 (CS1). Drives SPI_BUSY during the transaction and serialises read data back on the RTN_CLK/RTN_DAT return pair.

Parameters:
RTN_HALF, 4, return-clock half period in CLK cycles (minimum 1)
TIMEOUT, 255, CLK cycles allowed in REQ without REG_ACK before abort

Ports:
CLK  in  1  system clock; all logic on rising edge
RST  in  1  reset, asynchronous, active-high
SPI_CS0  in  1  chip select target 0, active-high, asynchronous to CLK
SPI_CS1  in  1  chip select target 1, active-high, asynchronous to CLK
SPI_CLK  in  1  SPI shift clock, asynchronous; data sampled on its rising edge
SPI_DAT  in  1  SPI serial data, MSB first
SPI_BUSY  out  1  transaction in progress
SPI_RTN_CLK  out  1  return clock, idle low
SPI_RTN_DAT  out  1  return data, MSB first
REG_REQ  out  1  register request, held until REG_ACK
REG_SEL  out  1  0 = target 0, 1 = target 1
REG_WR  out  1  1 = write, 0 = read
REG_ADDR  out  7  register address
REG_WDATA  out  8  write data
REG_RDATA  in  8  read data, valid with REG_ACK
REG_ACK  in  1  one-cycle completion strobe
FRAME_ERR  out  1  one-cycle pulse on any frame error
ERR_CNT  out  8  saturating error count

Behaviour:
- Reset: all outputs 0 except SPI_BUSY = 1. State = IDLE. SPI_BUSY clears on the first CLK edge after RST deasserts.
- SPI_CS0, SPI_CS1, SPI_CLK and SPI_DAT each pass through a 2-flop synchroniser. SPI_CLK rising edge = synced high AND previous synced value low. Input latency is 2 CLK cycles.
- Frame format, 16 bits MSB first: bit15 = R/W (1 = write), bits14:8 = address, bits7:0 = write data (ignored for reads).
- IDLE:
  - Exactly one synced CS high: latch sel, clear the bit counter, go to SHIFT.
  - Both CS high: FRAME_ERR pulse, go to DONE.
- SHIFT:
  - Each SPI_CLK rising edge shifts SPI_DAT into a 16-bit register and increments a 4-bit counter.
  - On the 16th edge: go to REQ and set SPI_BUSY = 1.
  - Selected CS drops before the 16th edge, or the other CS rises: FRAME_ERR pulse, go to IDLE.
- REQ:
  - REG_REQ = 1; REG_SEL, REG_WR, REG_ADDR and REG_WDATA stay stable until REG_ACK.
  - REG_ACK on a write: go to DONE.
  - REG_ACK on a read: load REG_RDATA into the return shifter, go to RTN.
  - REG_REQ drops the cycle after REG_ACK.
  - A timeout counter reaching TIMEOUT with no ACK: drop REG_REQ, FRAME_ERR pulse, go to DONE. No return data is sent.
- RTN:
  - SPI_RTN_CLK toggles every RTN_HALF cycles.
  - SPI_RTN_DAT is valid before the first rising edge and changes only after falling edges.
  - After 8 rising/falling pairs, SPI_RTN_CLK ends low and SPI_RTN_DAT returns to 0. Go to DONE.
- DONE: SPI_BUSY = 0. Wait until both synced CS are low, then go to IDLE. This prevents re-triggering inside one CS assertion.
- CS released during REQ or RTN: the transaction completes in full so no register access is torn.
- SPI_CLK edges outside SHIFT are ignored. Extra edges after the 16th are ignored.
- ERR_CNT increments on each FRAME_ERR and saturates at 255. It clears only on RST.
- RST asserted mid-operation: immediate return to reset values; REG_REQ drops asynchronously.
- SPI_BUSY = 1 only in REQ and RTN (and during reset).

Test Plan:
- Write: CS0 high, frame 0x85A5 -> REG_REQ with SEL=0, WR=1, ADDR=0x05, WDATA=0xA5. ACK after 3 cycles -> BUSY low, no RTN_CLK activity.
- Read: CS1 high, frame 0x1200, REG_RDATA = 0xC3 with ACK -> SEL=1, WR=0, ADDR=0x12. RTN_DAT bits 1,1,0,0,0,0,1,1 on 8 RTN_CLK rising edges, RTN_CLK half period = 4 CLK.
- Abort: CS0 dropped after 9 SPI_CLK edges -> FRAME_ERR pulse, ERR_CNT = 1, no REG_REQ.
- Conflict: CS0 and CS1 both high -> FRAME_ERR, no REG_REQ. Both released, then a valid CS0 frame -> normal transaction.
- Timeout: valid read, ACK never sent -> REG_REQ drops after 255 cycles, FRAME_ERR, BUSY low, RTN_CLK stays low.
- Saturation and reset: 260 abort frames -> ERR_CNT = 255. RST asserted during RTN -> RTN_CLK = 0, BUSY = 1 during reset, ERR_CNT = 0.

Source files
------------

// File: rtl/ff_emu_spi_ctrl.sv
// ff_emu_spi_ctrl: oversampled SPI slave that turns 16-bit frames into register-bus
// transactions and serialises read data back on the return clock/data pair.
module ff_emu_spi_ctrl #(
  parameter int RTN_HALF = 4,
  parameter int TIMEOUT = 255
) (
  input  logic       CLK,
  input  logic       RST,
  input  logic       SPI_CS0,
  input  logic       SPI_CS1,
  input  logic       SPI_CLK,
  input  logic       SPI_DAT,
  output logic       SPI_BUSY,
  output logic       SPI_RTN_CLK,
  output logic       SPI_RTN_DAT,
  output logic       REG_REQ,
  output logic       REG_SEL,
  output logic       REG_WR,
  output logic [6:0] REG_ADDR,
  output logic [7:0] REG_WDATA,
  input  logic [7:0] REG_RDATA,
  input  logic       REG_ACK,
  output logic       FRAME_ERR,
  output logic [7:0] ERR_CNT
);
  typedef enum logic [2:0] {IDLE, SHIFT, REQ, RTN, DONE} state_t;
  state_t state, nxt;
  logic [3:0] s1, s2;
  logic clk_q, sel, rclk, err;
  logic [15:0] sh, tcnt, hcnt;
  logic [3:0] bcnt;
  logic [2:0] rbits;
  logic [7:0] rsh;
  logic cs0, cs1, rise, sel_cs, oth_cs, half_end, tmo;
  // synchronised inputs packed as {dat, clk, cs1, cs0}
  assign cs0 = s2[0];
  assign cs1 = s2[1];
  assign rise = s2[2] & ~clk_q;
  assign sel_cs = sel ? cs1 : cs0;
  assign oth_cs = sel ? cs0 : cs1;
  assign half_end = hcnt == 16'(RTN_HALF - 1);
  assign tmo = tcnt == 16'(TIMEOUT - 1);
  assign REG_REQ = state == REQ;
  assign REG_SEL = sel;
  assign REG_WR = sh[15];
  assign REG_ADDR = sh[14:8];
  assign REG_WDATA = sh[7:0];
  assign SPI_RTN_CLK = rclk;
  assign SPI_RTN_DAT = (state == RTN) & rsh[7];
  always_ff @(posedge CLK or posedge RST)
    if (RST) state <= IDLE;
    else state <= nxt;
  always_comb begin
    nxt = state;
    err = 1'b0;
    case (state)
      IDLE: if (cs0 & cs1) begin err = 1'b1; nxt = DONE; end
            else if (cs0 | cs1) nxt = SHIFT;
      SHIFT: if (!sel_cs || oth_cs) begin err = 1'b1; nxt = IDLE; end
             else if (rise && bcnt == 4'd15) nxt = REQ;
      REQ: if (REG_ACK) nxt = sh[15] ? DONE : RTN;
           else if (tmo) begin err = 1'b1; nxt = DONE; end
      RTN: if (half_end && rclk && rbits == 3'd7) nxt = DONE;
      DONE: if (!cs0 && !cs1) nxt = IDLE;
      default: nxt = IDLE;
    endcase
  end
  always_ff @(posedge CLK or posedge RST)
    if (RST) begin
      s1 <= '0;
      s2 <= '0;
      clk_q <= 1'b0;
      SPI_BUSY <= 1'b1;
      FRAME_ERR <= 1'b0;
      ERR_CNT <= '0;
      sel <= 1'b0;
      sh <= '0;
      bcnt <= '0;
      tcnt <= '0;
      hcnt <= '0;
      rclk <= 1'b0;
      rbits <= '0;
      rsh <= '0;
    end else begin
      s1 <= {SPI_DAT, SPI_CLK, SPI_CS1, SPI_CS0};
      s2 <= s1;
      clk_q <= s2[2];
      SPI_BUSY <= nxt == REQ || nxt == RTN;
      FRAME_ERR <= err;
      if (err && ERR_CNT != 8'hff) ERR_CNT <= ERR_CNT + 8'd1;
      if (state == IDLE) begin
        sel <= cs1;
        bcnt <= '0;
      end
      if (state == SHIFT && rise) begin
        sh <= {sh[14:0], s2[3]};
        bcnt <= bcnt + 4'd1;
      end
      tcnt <= state == REQ ? tcnt + 16'd1 : '0;
      if (state == REQ && REG_ACK) rsh <= REG_RDATA;
      // data advances only on the falling return edge so it is stable at each rise
      if (state == RTN) begin
        hcnt <= half_end ? '0 : hcnt + 16'd1;
        if (half_end) begin
          rclk <= ~rclk;
          if (rclk) begin
            rsh <= {rsh[6:0], 1'b0};
            rbits <= rbits + 3'd1;
          end
        end
      end else begin
        hcnt <= '0;
        rclk <= 1'b0;
        rbits <= '0;
      end
    end
endmodule

// File: tb/tb_ff_emu_spi_ctrl.sv
// tb_ff_emu_spi_ctrl: directed bench with a request/read-data scoreboard
module tb_ff_emu_spi_ctrl;
  logic CLK = 1'b0, RST = 1'b1;
  logic SPI_CS0 = 1'b0, SPI_CS1 = 1'b0, SPI_CLK = 1'b0, SPI_DAT = 1'b0;
  logic [7:0] REG_RDATA = '0;
  logic REG_ACK = 1'b0;
  logic SPI_BUSY, SPI_RTN_CLK, SPI_RTN_DAT, REG_REQ, REG_SEL, REG_WR, FRAME_ERR;
  logic [6:0] REG_ADDR;
  logic [7:0] REG_WDATA, ERR_CNT;

  typedef struct packed {logic sel; logic wr; logic [6:0] addr; logic [7:0] wdata;} req_t;
  req_t exp_q[$];
  logic [7:0] rd_q[$];
  req_t last_e;
  int tests = 0, fails = 0;
  int errs = 0, reqs = 0, rtns = 0;
  logic req_q = 1'b0;
  logic [7:0] rcap = '0;
  longint last_rise = 0, period = 0;

  ff_emu_spi_ctrl #(.RTN_HALF(4), .TIMEOUT(255)) dut (
    .CLK(CLK), .RST(RST), .SPI_CS0(SPI_CS0), .SPI_CS1(SPI_CS1), .SPI_CLK(SPI_CLK),
    .SPI_DAT(SPI_DAT), .SPI_BUSY(SPI_BUSY), .SPI_RTN_CLK(SPI_RTN_CLK),
    .SPI_RTN_DAT(SPI_RTN_DAT), .REG_REQ(REG_REQ), .REG_SEL(REG_SEL), .REG_WR(REG_WR),
    .REG_ADDR(REG_ADDR), .REG_WDATA(REG_WDATA), .REG_RDATA(REG_RDATA), .REG_ACK(REG_ACK),
    .FRAME_ERR(FRAME_ERR), .ERR_CNT(ERR_CNT)
  );

  always #5 CLK = ~CLK;

  always @(negedge CLK) begin
    if (FRAME_ERR === 1'b1) errs++;
    if (REG_REQ === 1'b1 && !req_q) reqs++;
    req_q = REG_REQ === 1'b1;
  end

  always @(posedge SPI_RTN_CLK) begin
    rtns++;
    rcap = {rcap[6:0], SPI_RTN_DAT};
    period = longint'($time) - last_rise;
    last_rise = longint'($time);
  end

  task automatic tick(input int n);
    repeat (n) @(posedge CLK);
    #1;
  endtask

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    tests++;
    assert (got === exp) else begin
      fails++;
      $error("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  task automatic send(input logic [15:0] f, input int n);
    for (int i = 0; i < n; i++) begin
      SPI_DAT = f[15-i];
      tick(3);
      SPI_CLK = 1'b1;
      tick(3);
      SPI_CLK = 1'b0;
    end
  endtask

  task automatic wait_req;
    int n = 0;
    while (REG_REQ !== 1'b1 && n < 100) begin tick(1); n++; end
    check("req_seen", REG_REQ, 1);
  endtask

  task automatic pop_check(input string tag);
    last_e = exp_q.pop_front();
    check(tag, {REG_SEL, REG_WR, REG_ADDR, REG_WDATA}, last_e);
  endtask

  task automatic ack(input logic [7:0] d);
    REG_RDATA = d;
    REG_ACK = 1'b1;
    tick(1);
    REG_ACK = 1'b0;
  endtask

  task automatic wait_idle;
    int n = 0;
    while (SPI_BUSY !== 1'b0 && n < 300) begin tick(1); n++; end
    check("busy_clear", SPI_BUSY, 0);
  endtask

  initial begin
    int e0, r0, t0, n;
    tick(3);
    check("rst_busy", SPI_BUSY, 1);
    check("rst_req", REG_REQ, 0);
    check("rst_errcnt", ERR_CNT, 0);
    check("rst_rtnclk", SPI_RTN_CLK, 0);
    RST = 1'b0;
    tick(1);
    check("busy_after_rst", SPI_BUSY, 0);

    // write on CS0
    r0 = rtns;
    exp_q.push_back('{1'b0, 1'b1, 7'h05, 8'hA5});
    SPI_CS0 = 1'b1;
    tick(4);
    send(16'h85A5, 16);
    wait_req();
    pop_check("wr_fields");
    check("wr_busy", SPI_BUSY, 1);
    tick(3);
    ack(8'h00);
    check("wr_busy_low", SPI_BUSY, 0);
    check("wr_req_low", REG_REQ, 0);
    tick(10);
    check("wr_no_rtn", rtns - r0, 0);
    SPI_CS0 = 1'b0;
    tick(6);

    // read on CS1 with return data
    r0 = rtns;
    exp_q.push_back('{1'b1, 1'b0, 7'h12, 8'h00});
    rd_q.push_back(8'hC3);
    SPI_CS1 = 1'b1;
    tick(4);
    send(16'h1200, 16);
    wait_req();
    pop_check("rd_fields");
    ack(8'hC3);
    check("rd_busy", SPI_BUSY, 1);
    wait_idle();
    check("rd_rtn_edges", rtns - r0, 8);
    check("rd_rtn_data", rcap, rd_q.pop_front());
    check("rd_rtn_period", 32'(period), 80);
    check("rd_rtnclk_low", SPI_RTN_CLK, 0);
    check("rd_rtndat_low", SPI_RTN_DAT, 0);
    SPI_CS1 = 1'b0;
    tick(6);

    // abort after 9 edges
    e0 = errs; t0 = reqs;
    SPI_CS0 = 1'b1;
    tick(4);
    send(16'hFFFF, 9);
    SPI_CS0 = 1'b0;
    tick(10);
    check("abort_err", errs - e0, 1);
    check("abort_cnt", ERR_CNT, 1);
    check("abort_noreq", reqs - t0, 0);

    // conflicting chip selects, then a good frame with trailing extra edges
    e0 = errs; t0 = reqs;
    SPI_CS0 = 1'b1; SPI_CS1 = 1'b1;
    tick(8);
    check("conf_err", errs - e0, 1);
    check("conf_cnt", ERR_CNT, 2);
    check("conf_noreq", reqs - t0, 0);
    SPI_CS0 = 1'b0; SPI_CS1 = 1'b0;
    tick(5);
    exp_q.push_back('{1'b0, 1'b1, 7'h7F, 8'h3C});
    SPI_CS0 = 1'b1;
    tick(4);
    send(16'hFF3C, 16);
    wait_req();
    pop_check("conf_wr_fields");
    send(16'h0000, 2);
    check("extra_edges_hold", {REG_SEL, REG_WR, REG_ADDR, REG_WDATA}, last_e);
    ack(8'h00);
    check("conf_wr_done", SPI_BUSY, 0);
    SPI_CS0 = 1'b0;
    tick(6);

    // timeout on a read
    e0 = errs; r0 = rtns;
    exp_q.push_back('{1'b1, 1'b0, 7'h34, 8'h00});
    SPI_CS1 = 1'b1;
    tick(4);
    send(16'h3400, 16);
    wait_req();
    pop_check("tmo_fields");
    n = 0;
    while (REG_REQ === 1'b1 && n < 400) begin tick(1); n++; end
    check("tmo_cycles", n, 255);
    tick(2);
    check("tmo_err", errs - e0, 1);
    check("tmo_cnt", ERR_CNT, 3);
    check("tmo_busy", SPI_BUSY, 0);
    check("tmo_no_rtn", rtns - r0, 0);
    SPI_CS1 = 1'b0;
    tick(6);

    // saturation
    e0 = errs;
    for (int i = 0; i < 260; i++) begin
      SPI_CS0 = 1'b1;
      tick(4);
      SPI_CS0 = 1'b0;
      tick(4);
    end
    tick(4);
    check("sat_pulses", errs - e0, 260);
    check("sat_cnt", ERR_CNT, 255);

    // reset during return
    r0 = rtns;
    exp_q.push_back('{1'b1, 1'b0, 7'h01, 8'h00});
    SPI_CS1 = 1'b1;
    tick(4);
    send(16'h0100, 16);
    wait_req();
    pop_check("rst_rd_fields");
    ack(8'hA5);
    tick(20);
    check("rst_rtn_active", rtns > r0, 1);
    #3 RST = 1'b1;
    #1;
    check("mid_rst_rtnclk", SPI_RTN_CLK, 0);
    check("mid_rst_busy", SPI_BUSY, 1);
    check("mid_rst_errcnt", ERR_CNT, 0);
    check("mid_rst_req", REG_REQ, 0);
    SPI_CS1 = 1'b0;
    tick(2);
    RST = 1'b0;
    tick(2);
    check("post_rst_busy", SPI_BUSY, 0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end
endmodule
